// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit multiplexed seven-segment scanner.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [3:0]  AN_OFF     = 4'hF;

  typedef logic [1:0] digit_idx_t;

  // One complete display word: four BCD digits plus their decimal points.
  typedef struct packed {
    logic [15:0] bcd;
    logic [3:0]  dp;
  } disp_word_t;

endpackage : seg7_pkg

// File: rtl/segment7.sv
// BCD to active-low seven-segment decoder, {a..g}; non-BCD codes render blank.
module segment7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = 7'b0000001;
      4'd1:    seg_c = 7'b1001111;
      4'd2:    seg_c = 7'b0010010;
      4'd3:    seg_c = 7'b0000110;
      4'd4:    seg_c = 7'b1001100;
      4'd5:    seg_c = 7'b0100100;
      4'd6:    seg_c = 7'b0100000;
      4'd7:    seg_c = 7'b0001111;
      4'd8:    seg_c = 7'b0000000;
      4'd9:    seg_c = 7'b0000100;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule : segment7

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan of four BCD digits with a one-deep load buffer that is
// committed only at frame boundaries, leading-zero blanking and anti-ghost gaps.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  input  logic [15:0] load_bcd,
  input  logic [3:0]  load_dp,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
  localparam digit_idx_t       IDX_LAST  = digit_idx_t'(NUM_DIGITS - 1);

  logic [CNT_W-1:0] cnt;
  digit_idx_t       idx;
  disp_word_t       active;
  disp_word_t       pending;
  logic             pending_full;

  logic       slot_end_c;
  logic       frame_end_c;
  logic       accept_c;
  logic [3:0] cur_bcd_c;
  logic [6:0] dec_seg_c;
  logic       lz_blank_c;

  assign slot_end_c  = (cnt == CNT_LAST);
  assign frame_end_c = slot_end_c && (idx == IDX_LAST);
  assign accept_c    = load_valid && !pending_full;
  assign load_ready  = !pending_full;
  assign cur_bcd_c   = active.bcd[{idx, 2'b00} +: 4];

  // A digit is a leading zero when it and every more-significant digit are zero.
  always_comb begin
    logic z3, z2, z1;
    z3 = (active.bcd[15:12] == 4'd0);
    z2 = z3 && (active.bcd[11:8] == 4'd0);
    z1 = z2 && (active.bcd[7:4] == 4'd0);
    lz_blank_c = 1'b0;
    case (idx)
      2'd1:    lz_blank_c = blank_lz && z1;
      2'd2:    lz_blank_c = blank_lz && z2;
      2'd3:    lz_blank_c = blank_lz && z3;
      default: lz_blank_c = 1'b0;
    endcase
  end

  segment7 u_segment7 (
    .bcd   (cur_bcd_c),
    .seg_c (dec_seg_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      frame_tick   <= 1'b0;
      an           <= AN_OFF;
      seg          <= SEG_BLANK;
      dp           <= 1'b1;
    end else begin
      cnt        <= slot_end_c ? '0 : cnt + CNT_W'(1);
      frame_tick <= frame_end_c;
      if (slot_end_c) begin
        idx <= idx + digit_idx_t'(1);
      end

      // Accept and commit are exclusive: accept needs the buffer empty.
      if (accept_c) begin
        pending      <= '{bcd: load_bcd, dp: load_dp};
        pending_full <= 1'b1;
      end else if (frame_end_c && pending_full) begin
        active       <= pending;
        pending_full <= 1'b0;
      end

      if (cnt < BLANK_END) begin
        an  <= AN_OFF;
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx);
        seg <= lz_blank_c ? SEG_BLANK : dec_seg_c;
        dp  <= !active.dp[idx];
      end
    end
  end

endmodule : seg7_scan_ctrl
